ram_bus_bridge: RTL

- Upstream stage of the word-wide on-chip RAM: converts the picorv32 native memory interface (valid/ready, byte-strobed) into the RAM's ce/wr/addr/d/q port.
- Performs address-window decode, one-cycle RAM read-latency handling and the ready handshake.
- Flags out-of-window accesses with a sticky error.
- Sits between the CPU core and the RAM in the top-level SoC.

---
 rtl/ram_bus_bridge.sv | 135 +++++++++++++
 1 files changed

// File: rtl/ram_bus_bridge.sv
// ram_bus_bridge: picorv32 native memory bus to single-port word RAM, with window decode and sticky error.
// Optional RAM_BUS_BRIDGE_RDATA_REG_EN registers ram_q before returning it (3-cycle transaction).
module ram_bus_bridge #(
    parameter int unsigned ADDR_W   = 16,
    parameter logic [31:0] BASE     = 32'h0000_0000,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_valid,
    input  logic              mem_instr,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic [3:0]        mem_wstrb,
    output logic              mem_ready,
    output logic [31:0]       mem_rdata,
    output logic              ram_ce,
    output logic [3:0]        ram_wr,
    output logic [31:0]       ram_d,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [31:0]       ram_q,
    output logic              err,
    output logic [31:0]       err_addr
);

    localparam logic [32:0] WIN_BYTES = 33'd4 << ADDR_W;

    typedef enum logic [2:0] {
        IDLE,
        RESP,
        RESP_ERR,
        CAPTURE,
        CAPTURE_ERR
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] offset;
    logic        in_window;
    logic        accept_bad;
    logic        is_read;
`ifdef RAM_BUS_BRIDGE_RDATA_REG_EN
    logic [31:0] rdata_q;
`endif

    logic unused_bits;
    assign unused_bits = &{1'b0, mem_instr, offset[1:0]};

    // Unsigned subtraction makes addresses below BASE wrap to large offsets.
    assign offset    = mem_addr - BASE;
    assign in_window = {1'b0, offset} < WIN_BYTES;
    assign ram_addr  = offset[ADDR_W+1:2];
    assign ram_d     = mem_wdata;

    always_comb begin
        state_next = state;
        ram_ce     = 1'b0;
        ram_wr     = '0;
        mem_ready  = 1'b0;
        mem_rdata  = '0;
        accept_bad = 1'b0;
        case (state)
            IDLE: begin
                if (mem_valid) begin
                    if (in_window) begin
                        ram_ce = 1'b1;
                        ram_wr = mem_wstrb;
`ifdef RAM_BUS_BRIDGE_RDATA_REG_EN
                        state_next = CAPTURE;
`else
                        state_next = RESP;
`endif
                    end else begin
                        accept_bad = 1'b1;
`ifdef RAM_BUS_BRIDGE_RDATA_REG_EN
                        state_next = CAPTURE_ERR;
`else
                        state_next = RESP_ERR;
`endif
                    end
                end
            end
            CAPTURE:     state_next = RESP;
            CAPTURE_ERR: state_next = RESP_ERR;
            RESP: begin
                mem_ready  = 1'b1;
`ifdef RAM_BUS_BRIDGE_RDATA_REG_EN
                mem_rdata  = rdata_q;
`else
                mem_rdata  = is_read ? ram_q : '0;
`endif
                state_next = IDLE;
            end
            RESP_ERR: begin
                mem_ready  = 1'b1;
                mem_rdata  = is_read ? ERR_DATA : '0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // Reset wins even over a response already in flight.
        if (rst) begin
            ram_ce     = 1'b0;
            ram_wr     = '0;
            mem_ready  = 1'b0;
            mem_rdata  = '0;
            accept_bad = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            err      <= 1'b0;
            err_addr <= '0;
            is_read  <= 1'b0;
`ifdef RAM_BUS_BRIDGE_RDATA_REG_EN
            rdata_q  <= '0;
`endif
        end else begin
            state <= state_next;
            if (state == IDLE && mem_valid)
                is_read <= (mem_wstrb == 4'b0000);
            if (accept_bad && !err) begin
                err      <= 1'b1;
                err_addr <= mem_addr;
            end
`ifdef RAM_BUS_BRIDGE_RDATA_REG_EN
            if (state == CAPTURE)
                rdata_q <= is_read ? ram_q : '0;
`endif
        end
    end

endmodule
